cmp_arbiter: RTL and testbench

- Shares one registered 32-bit magnitude comparator (1-cycle registered eq/lt/gt/ge/le flags, unsigned) between NREQ requesters, e.g. branch unit and set-less-than path.
- Round-robin arbitration, valid/ready handshake per requester.
- Signed comparison via MSB inversion before issue.
- Per-request condition code turned into a single "taken" bit plus raw flags, returned with a response handshake.

---
 rtl/cmp_arbiter.sv | 159 +++++++++++++++
 tb/tb_cmp_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one registered W-bit unsigned magnitude comparator
// between NREQ requesters with round-robin arbitration.
//
// Flow per request: IDLE (grant + capture operands) -> ISSUE (comparator
// samples cmp_a/cmp_b) -> WAIT (flags valid, build response) -> RESP
// (hold response until resp_ready).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready only in IDLE, one-hot)
//   req_a/req_b         packed operands, requester i at [i*W +: W]
//   req_cond            packed 3-bit condition codes
//   req_signed          per-requester two's-complement select
//   resp_valid/ready    response handshake
//   resp_id             index of the requester owning the response
//   resp_taken          evaluated condition
//   resp_flags          {eq,lt,gt,ge,le} from the comparator
//   cmp_a/cmp_b         registered comparator operands
//   cmp_eq..cmp_le      comparator flags, consumed only in WAIT
module cmp_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_cond,
  input  logic [NREQ-1:0]   req_signed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_taken,
  output logic [4:0]        resp_flags,
  output logic [W-1:0]      cmp_a,
  output logic [W-1:0]      cmp_b,
  input  logic              cmp_eq,
  input  logic              cmp_lt,
  input  logic              cmp_gt,
  input  logic              cmp_ge,
  input  logic              cmp_le
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   gnt_q;
  logic [2:0]      cond_q;

  // Per-requester views of the packed operand buses.
  logic [NREQ-1:0][W-1:0] a_arr, b_arr;
  logic [NREQ-1:0][2:0]   cond_arr;
  assign a_arr    = req_a;
  assign b_arr    = req_b;
  assign cond_arr = req_cond;

  // Round-robin pick: lowest valid index >= rr_ptr if any, otherwise the
  // lowest valid index overall (the wrap-around case).
  logic          gnt_vld, hi_vld;
  logic [PW-1:0] gnt_idx, hi_idx, lo_idx;

  always_comb begin
    gnt_vld = 1'b0;
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_vld = 1'b1;
        lo_idx  = PW'(i);
        if (PW'(i) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
    gnt_idx = hi_vld ? hi_idx : lo_idx;
  end

  logic accept;
  assign accept = (state_q == IDLE) && gnt_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Signed compare on an unsigned comparator: flipping the MSB of both
  // operands maps two's-complement order onto unsigned order.
  logic [W-1:0] smask;
  assign smask = {req_signed[gnt_idx], {(W-1){1'b0}}};

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (cond_q)
      3'd0: taken = cmp_eq;
      3'd1: taken = !cmp_eq;
      3'd2: taken = cmp_lt;
      3'd3: taken = cmp_ge;
      3'd4: taken = cmp_gt;
      3'd5: taken = cmp_le;
      3'd6: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (gnt_vld) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      cond_q     <= '0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_taken <= 1'b0;
      resp_flags <= '0;
    end else begin
      if (accept) begin
        cmp_a    <= a_arr[gnt_idx] ^ smask;
        cmp_b    <= b_arr[gnt_idx] ^ smask;
        cond_q   <= cond_arr[gnt_idx];
        gnt_q    <= gnt_idx;
        rr_ptr_q <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == WAIT) begin
        resp_flags <= {cmp_eq, cmp_lt, cmp_gt, cmp_ge, cmp_le};
        resp_id    <= IDW'(gnt_q);
        resp_taken <= taken;
        resp_valid <= 1'b1;
      end
      if (state_q == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a registered comparator model.
module tb_cmp_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 3;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_signed;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_cond;
  logic              resp_valid, resp_ready, resp_taken;
  logic [IDW-1:0]    resp_id;
  logic [4:0]        resp_flags;
  logic [W-1:0]      cmp_a, cmp_b;
  logic              cmp_eq, cmp_lt, cmp_gt, cmp_ge, cmp_le;

  int checks = 0;
  int errors = 0;

  cmp_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cond(req_cond), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_taken(resp_taken), .resp_flags(resp_flags),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_ge(cmp_ge), .cmp_le(cmp_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered unsigned comparator: flags one cycle after operands.
  always @(posedge clk) begin
    cmp_eq <= (cmp_a == cmp_b);
    cmp_lt <= (cmp_a <  cmp_b);
    cmp_gt <= (cmp_a >  cmp_b);
    cmp_ge <= (cmp_a >= cmp_b);
    cmp_le <= (cmp_a <= cmp_b);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic s);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_cond[i*3 +: 3] = c;
    req_signed[i]    = s;
  endtask

  // Single request from requester i with nothing else pending.
  task automatic req_cycle(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] c, input logic s,
                           input logic [31:0] eca, input logic [31:0] ecb,
                           input logic et, input logic [4:0] ef);
    logic [NREQ-1:0] er;
    er = '0;
    er[i] = 1'b1;
    set_req(i, a, b, c, s);
    req_valid = er;
    #1 chk({tag, "_ready"}, 64'(req_ready), 64'(er));
    cyc();
    req_valid = '0;
    req_a[i*W +: W] = ~a;  // changes after accept must not matter
    req_b[i*W +: W] = ~b;
    #1;
    chk({tag, "_cmp_a"}, 64'(cmp_a), 64'(eca));
    chk({tag, "_cmp_b"}, 64'(cmp_b), 64'(ecb));
    chk({tag, "_busy_ready"}, 64'(req_ready), 64'(0));
    cyc();
    chk({tag, "_early_valid"}, 64'(resp_valid), 64'(0));
    cyc();
    chk({tag, "_valid"}, 64'(resp_valid), 64'(1));
    chk({tag, "_id"}, 64'(resp_id), 64'(i));
    chk({tag, "_taken"}, 64'(resp_taken), 64'(et));
    chk({tag, "_flags"}, 64'(resp_flags), 64'(ef));
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    chk({tag, "_drain"}, 64'(resp_valid), 64'(0));
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; req_a = '0; req_b = '0; req_cond = '0;
    req_signed = '0; resp_ready = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_cmp_a", 64'(cmp_a), 64'(0));
    chk("rst_cmp_b", 64'(cmp_b), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_taken", 64'(resp_taken), 64'(0));
    chk("rst_flags", 64'(resp_flags), 64'(0));
    req_valid = '0;
    rst = 1'b0;
    cyc();

    // unsigned 5 < 7, LT
    req_cycle("lt_u", 0, 32'd5, 32'd7, 3'd2, 1'b0, 32'd5, 32'd7, 1'b1, 5'b01001);
    // signed -1 < 1
    req_cycle("lt_s", 0, 32'hFFFFFFFF, 32'd1, 3'd2, 1'b1,
              32'h7FFFFFFF, 32'h80000001, 1'b1, 5'b01001);
    // unsigned 0xFFFFFFFF > 1
    req_cycle("lt_uu", 0, 32'hFFFFFFFF, 32'd1, 3'd2, 1'b0,
              32'hFFFFFFFF, 32'd1, 1'b0, 5'b00110);

    // Round robin from reset, both valid, EQ vs NE on 9==9
    rst = 1'b1; cyc(); rst = 1'b0;
    set_req(0, 32'd9, 32'd9, 3'd0, 1'b0);
    set_req(1, 32'd9, 32'd9, 3'd1, 1'b0);
    req_valid = 2'b11;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rr_ready%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      cyc(); cyc(); cyc();
      chk($sformatf("rr_valid%0d", k), 64'(resp_valid), 64'(1));
      chk($sformatf("rr_id%0d", k), 64'(resp_id), 64'(k % 2));
      chk($sformatf("rr_taken%0d", k), 64'(resp_taken), (k % 2 == 0) ? 64'h1 : 64'h0);
      chk($sformatf("rr_rdy_in_resp%0d", k), 64'(req_ready), 64'(0));
      cyc();
    end
    req_valid = '0;
    resp_ready = 1'b0;

    // Backpressure: response held 5 cycles, requester 1 waits
    set_req(0, 32'd3, 32'd3, 3'd0, 1'b0);
    req_valid = 2'b01;
    #1 chk("bp_ready0", 64'(req_ready), 64'h1);
    cyc();
    req_valid = 2'b10;
    #1 chk("bp_issue_ready", 64'(req_ready), 64'(0));
    cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_valid%0d", k), 64'(resp_valid), 64'(1));
      chk($sformatf("bp_id%0d", k), 64'(resp_id), 64'(0));
      chk($sformatf("bp_taken%0d", k), 64'(resp_taken), 64'(1));
      chk($sformatf("bp_flags%0d", k), 64'(resp_flags), 64'(5'b10011));
      chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'(0));
      cyc();
    end
    resp_ready = 1'b1;
    #1 chk("bp_hs_ready", 64'(req_ready), 64'(0));
    chk("bp_hs_valid", 64'(resp_valid), 64'(1));
    cyc();
    resp_ready = 1'b0;
    #1 chk("bp_accept1", 64'(req_ready), 64'h2);
    chk("bp_idle_valid", 64'(resp_valid), 64'(0));
    cyc();
    req_valid = '0;
    chk("bp_cmp_a1", 64'(cmp_a), 64'd9);
    cyc(); cyc();
    chk("bp_id1", 64'(resp_id), 64'(1));
    chk("bp_taken1", 64'(resp_taken), 64'(0));
    chk("bp_flags1", 64'(resp_flags), 64'(5'b10011));
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;

    // Reset while in ISSUE discards the request
    set_req(0, 32'd5, 32'd7, 3'd2, 1'b0);
    req_valid = 2'b01;
    cyc();
    req_valid = '0;
    rst = 1'b1;
    chk("rsti_cmp_a_before", 64'(cmp_a), 64'd5);
    cyc();
    rst = 1'b0;
    chk("rsti_cmp_a", 64'(cmp_a), 64'(0));
    chk("rsti_valid", 64'(resp_valid), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rsti_novalid%0d", k), 64'(resp_valid), 64'(0));
      cyc();
    end

    // ALWAYS with 5<7, then NEVER with 9==9; first grant shows rr_ptr==0
    set_req(0, 32'd5, 32'd7, 3'd6, 1'b0);
    set_req(1, 32'd9, 32'd9, 3'd7, 1'b0);
    req_valid = 2'b11;
    #1 chk("al_ready_ptr0", 64'(req_ready), 64'h1);
    cyc();
    req_valid = 2'b10;
    cyc(); cyc();
    chk("al_id", 64'(resp_id), 64'(0));
    chk("al_taken", 64'(resp_taken), 64'(1));
    chk("al_flags", 64'(resp_flags), 64'(5'b01001));
    resp_ready = 1'b1;
    cyc();
    #1 chk("nv_ready", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    cyc(); cyc();
    chk("nv_valid", 64'(resp_valid), 64'(1));
    chk("nv_id", 64'(resp_id), 64'(1));
    chk("nv_taken", 64'(resp_taken), 64'(0));
    chk("nv_flags", 64'(resp_flags), 64'(5'b10011));
    cyc();
    chk("nv_drain", 64'(resp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
